// File: rtl/spi_mem_bridge.sv
// spi_mem_bridge: converts CPU bus read/write cycles into SPI memory transactions on a
// shared byte-level SPI engine. Each access is a command byte, SPI_ADDR_BYTES address
// bytes (zero-extended, MSB first) and one data byte. An access is followed by one dummy
// byte of clocks with every chip select high, which gives the device its deselect gap.
//
// Optional feature, enabled by defining SPI_MEM_SEQ_READ_EN: after a read the device stays
// selected in a HOLD state. A read of the next sequential address on that device then sends
// only the data byte.
//
// Ports:
//   clk, rst_n       clock and asynchronous active-low reset
//   bus_address      request address; the top log2(NUM_CS) bits select the device
//   bus_data_tx      write data
//   bus_data_rx      registered read data
//   bus_read/write   level requests, held until ack (read wins if both are high)
//   bus_wait         low for exactly one cycle to acknowledge an access
//   spi_data_tx      byte for the engine to shift out
//   spi_data_rx      byte received by the engine
//   spi_txn_start    start one byte transfer
//   spi_txn_done     engine idle/done (high when idle)
//   spi_force_clock  one dummy byte of clocks with all chip selects high
//   spi_ce_n         active-low chip selects
module spi_mem_bridge #(
  parameter int unsigned       ADDR_W         = 16,
  parameter int unsigned       NUM_CS         = 2,
  parameter int unsigned       SPI_ADDR_BYTES = 3,
  parameter logic [NUM_CS-1:0] WRITE_MASK     = 2'b10,
  parameter logic [7:0]        READ_CMD       = 8'h03,
  parameter logic [7:0]        WRITE_CMD      = 8'h02
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] bus_address,
  input  logic [7:0]        bus_data_tx,
  output logic [7:0]        bus_data_rx,
  input  logic              bus_read,
  input  logic              bus_write,
  output logic              bus_wait,
  output logic [7:0]        spi_data_tx,
  input  logic [7:0]        spi_data_rx,
  output logic              spi_txn_start,
  input  logic              spi_txn_done,
  output logic              spi_force_clock,
  output logic [NUM_CS-1:0] spi_ce_n
);

  localparam int unsigned CsW     = $clog2(NUM_CS);
  localparam int unsigned CntW    = $clog2(SPI_ADDR_BYTES + 2);
  localparam int unsigned ExtW    = SPI_ADDR_BYTES * 8;
  localparam int unsigned InW     = ADDR_W - CsW;
  localparam logic [CntW-1:0] LastIdx = CntW'(SPI_ADDR_BYTES + 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StWait,
    StAck,
    StGapStart,
    StGapWait
`ifdef SPI_MEM_SEQ_READ_EN
    , StHold
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              rd_q, rd_d;
  // Set for a write to a write-protected device: acked without any SPI traffic.
  logic              masked_q, masked_d;
  logic [7:0]        rx_q, rx_d;
  logic              start_q, start_d;
  logic              force_q, force_d;
  logic [CsW-1:0]    dev;
  logic [ExtW-1:0]   addr_ext;

`ifdef SPI_MEM_SEQ_READ_EN
  // Cleared when the post-read increment wrapped the in-device field, which rules out a
  // sequential continuation.
  logic              hold_ok_q, hold_ok_d;
  logic [InW-1:0]    in_addr;
  assign in_addr = addr_q[InW-1:0];
`endif

  assign dev = addr_q[ADDR_W-1 -: CsW];

  // Outgoing byte selected by the byte counter.
  always_comb begin
    addr_ext = '0;
    for (int unsigned i = 0; i < ExtW; i++) begin
      if (i < ADDR_W) addr_ext[i] = addr_q[i];
    end
    spi_data_tx = 8'h00;
    if (cnt_q == '0) begin
      spi_data_tx = rd_q ? READ_CMD : WRITE_CMD;
    end else if (cnt_q == LastIdx) begin
      spi_data_tx = rd_q ? 8'h00 : data_q;
    end else begin
      for (int unsigned k = 1; k <= SPI_ADDR_BYTES; k++) begin
        if (cnt_q == CntW'(k)) spi_data_tx = addr_ext[(SPI_ADDR_BYTES - k) * 8 +: 8];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    rd_d      = rd_q;
    masked_d  = masked_q;
    rx_d      = rx_q;
    start_d   = start_q;
    force_d   = force_q;
`ifdef SPI_MEM_SEQ_READ_EN
    hold_ok_d = hold_ok_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus_read || bus_write) begin
          addr_d   = bus_address;
          data_d   = bus_data_tx;
          rd_d     = bus_read;
          cnt_d    = '0;
          masked_d = !bus_read && !WRITE_MASK[bus_address[ADDR_W-1 -: CsW]];
          if (masked_d) begin
            state_d = StAck;
          end else begin
            start_d = 1'b1;
            state_d = StStart;
          end
        end
      end
      StStart: begin
        if (!spi_txn_done) begin
          start_d = 1'b0;
          state_d = StWait;
        end
      end
      StWait: begin
        if (spi_txn_done) begin
          if (cnt_q != LastIdx) begin
            cnt_d   = cnt_q + 1'b1;
            start_d = 1'b1;
            state_d = StStart;
          end else begin
            if (rd_q) rx_d = spi_data_rx;
            cnt_d   = '0;
            state_d = StAck;
          end
        end
      end
      StAck: begin
        if (masked_q) begin
          state_d = StIdle;
`ifdef SPI_MEM_SEQ_READ_EN
        end else if (rd_q) begin
          // Keep the device selected and pre-compute the next sequential address; the
          // increment never carries into the device field.
          addr_d    = {dev, in_addr + InW'(1)};
          hold_ok_d = (in_addr != '1);
          state_d   = StHold;
`endif
        end else begin
          force_d = 1'b1;
          state_d = StGapStart;
        end
      end
      StGapStart: begin
        if (!spi_txn_done) begin
          force_d = 1'b0;
          state_d = StGapWait;
        end
      end
      StGapWait: begin
        if (spi_txn_done) state_d = StIdle;
      end
`ifdef SPI_MEM_SEQ_READ_EN
      StHold: begin
        if (bus_read && hold_ok_q && (bus_address == addr_q)) begin
          cnt_d   = LastIdx;
          start_d = 1'b1;
          state_d = StStart;
        end else if (bus_read || bus_write) begin
          // Close the burst; the request is picked up again from IDLE.
          force_d = 1'b1;
          state_d = StGapStart;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      rd_q      <= 1'b0;
      masked_q  <= 1'b0;
      rx_q      <= '0;
      start_q   <= 1'b0;
      force_q   <= 1'b0;
`ifdef SPI_MEM_SEQ_READ_EN
      hold_ok_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      rd_q      <= rd_d;
      masked_q  <= masked_d;
      rx_q      <= rx_d;
      start_q   <= start_d;
      force_q   <= force_d;
`ifdef SPI_MEM_SEQ_READ_EN
      hold_ok_q <= hold_ok_d;
`endif
    end
  end

  // Chip select decoded straight from state so reset deselects immediately.
  always_comb begin
    spi_ce_n = '1;
    if (!masked_q && (state_q == StStart || state_q == StWait || state_q == StAck
`ifdef SPI_MEM_SEQ_READ_EN
                      || state_q == StHold
`endif
                      )) begin
      spi_ce_n[dev] = 1'b0;
    end
  end

  assign bus_wait        = (state_q != StAck);
  assign bus_data_rx     = rx_q;
  assign spi_txn_start   = start_q;
  assign spi_force_clock = force_q;

endmodule

// File: tb/tb_spi_mem_bridge.sv
// Self-checking bench for spi_mem_bridge with a behavioural byte engine. Expected SPI bytes
// are queued when a bus access is driven; the engine logs what it actually saw.
module tb_spi_mem_bridge;

`ifdef SPI_MEM_SEQ_READ_EN
  localparam bit Seq = 1'b1;
`else
  localparam bit Seq = 1'b0;
`endif
  localparam logic [1:0] WMask = 2'b10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] bus_address = '0;
  logic [7:0]  bus_data_tx = '0;
  logic [7:0]  bus_data_rx;
  logic        bus_read = 1'b0;
  logic        bus_write = 1'b0;
  logic        bus_wait;
  logic [7:0]  spi_data_tx;
  logic [7:0]  spi_data_rx;
  logic        spi_txn_start;
  logic        spi_txn_done;
  logic        spi_force_clock;
  logic [1:0]  spi_ce_n;

  int vectors = 0;
  int miscompares = 0;

  // Engine model state
  logic       eng_done;
  int         eng_busy;
  int         start_cnt;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0] cap_tx[$];
  logic [1:0] cap_ce[$];
  logic [1:0] gap_ce[$];

  // Scoreboard / reference model state
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_rx = 8'h00;
  bit          in_hold = 1'b0;
  bit          hold_ok = 1'b0;
  logic [15:0] hold_addr = '0;

  always #5 clk = ~clk;

  spi_mem_bridge dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus_address    (bus_address),
    .bus_data_tx    (bus_data_tx),
    .bus_data_rx    (bus_data_rx),
    .bus_read       (bus_read),
    .bus_write      (bus_write),
    .bus_wait       (bus_wait),
    .spi_data_tx    (spi_data_tx),
    .spi_data_rx    (spi_data_rx),
    .spi_txn_start  (spi_txn_start),
    .spi_txn_done   (spi_txn_done),
    .spi_force_clock(spi_force_clock),
    .spi_ce_n       (spi_ce_n)
  );

  assign spi_txn_done = eng_done;
  assign spi_data_rx  = rx_byte;

  // Byte engine: accepts a start or forced-clock request while idle, busy for 3 cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_done <= 1'b1;
      eng_busy <= 0;
    end else if (eng_busy > 0) begin
      eng_busy <= eng_busy - 1;
      if (eng_busy == 1) eng_done <= 1'b1;
    end else if (eng_done && spi_txn_start) begin
      eng_done  <= 1'b0;
      eng_busy  <= 3;
      start_cnt <= start_cnt + 1;
      cap_tx.push_back(spi_data_tx);
      cap_ce.push_back(spi_ce_n);
    end else if (eng_done && spi_force_clock) begin
      eng_done <= 1'b0;
      eng_busy <= 3;
      gap_ce.push_back(spi_ce_n);
    end
  end

  initial start_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_access(input logic rd, input logic wr, input logic [15:0] addr,
                           input logic [7:0] wdata, input logic [7:0] rxv, input string tag);
    logic       dev;
    logic [1:0] ce_exp;
    bit         masked;
    bit         seq_hit;
    bit         was_hold;
    int         gaps_exp;
    int         start0;
    int         lat;
    int         n;
    dev      = addr[15];
    ce_exp   = dev ? 2'b01 : 2'b10;
    masked   = !rd && !WMask[dev];
    seq_hit  = Seq && in_hold && rd && hold_ok && (addr == hold_addr);
    was_hold = in_hold;
    gaps_exp = (in_hold && !seq_hit) ? 1 : 0;
    if (rd) begin
      if (!Seq) gaps_exp++;
    end else if (!masked) begin
      gaps_exp++;
    end
    if (!masked) begin
      if (!seq_hit) begin
        exp_q.push_back(rd ? 8'h03 : 8'h02);
        exp_q.push_back(8'h00);
        exp_q.push_back(addr[15:8]);
        exp_q.push_back(addr[7:0]);
      end
      exp_q.push_back(rd ? 8'h00 : wdata);
    end
    if (rd) exp_rx = rxv;
    rx_byte = rxv;
    start0  = start_cnt;
    gap_ce.delete();

    @(posedge clk); #1;
    bus_read    = rd;
    bus_write   = wr;
    bus_address = addr;
    bus_data_tx = wdata;
    lat = 0;
    while (bus_wait !== 1'b0 && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_ack"}, bus_wait, 1'b0);
    chk({tag, "_rx"}, bus_data_rx, exp_rx);
    chk({tag, "_ce_ack"}, spi_ce_n, masked ? 2'b11 : ce_exp);
    if (masked) begin
      chk({tag, "_no_start"}, start_cnt - start0, 0);
      if (!was_hold) chk({tag, "_lat_le2"}, lat <= 2, 1'b1);
    end
    @(posedge clk); #1;
    bus_read  = 1'b0;
    bus_write = 1'b0;
    chk({tag, "_wait_1cyc"}, bus_wait, 1'b1);
    repeat (15) @(posedge clk);
    #1;

    // Scoreboard drain: expected bytes vs engine log
    chk({tag, "_nbytes"}, cap_tx.size(), exp_q.size());
    n = (cap_tx.size() < exp_q.size()) ? cap_tx.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_tx"}, cap_tx.pop_front(), exp_q.pop_front());
      chk({tag, "_ce_byte"}, cap_ce.pop_front(), ce_exp);
    end
    cap_tx.delete();
    cap_ce.delete();
    exp_q.delete();
    chk({tag, "_ngaps"}, gap_ce.size(), gaps_exp);
    while (gap_ce.size() > 0) chk({tag, "_gap_ce"}, gap_ce.pop_front(), 2'b11);

    if (rd) begin
      in_hold   = Seq;
      hold_addr = {addr[15], addr[14:0] + 15'd1};
      hold_ok   = (addr[14:0] != 15'h7fff);
    end else begin
      in_hold = 1'b0;
    end
    chk({tag, "_ce_end"}, spi_ce_n, in_hold ? ce_exp : 2'b11);
  endtask

  initial begin
    int guard;
    // Reset state
    #1;
    chk("rst_rx", bus_data_rx, 8'h00);
    chk("rst_wait", bus_wait, 1'b1);
    chk("rst_start", spi_txn_start, 1'b0);
    chk("rst_force", spi_force_clock, 1'b0);
    chk("rst_ce", spi_ce_n, 2'b11);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    do_access(1'b1, 1'b0, 16'h1234, 8'h00, 8'hA5, "rd1234");
    do_access(1'b0, 1'b1, 16'h8010, 8'h5C, 8'h77, "wr8010");
    do_access(1'b0, 1'b1, 16'h0040, 8'h99, 8'h66, "wr_masked");
    do_access(1'b1, 1'b1, 16'h0001, 8'h11, 8'h3C, "rd_wr_both");

    // Reset in the middle of address byte 2
    rx_byte = 8'h42;
    @(posedge clk); #1;
    bus_read    = 1'b1;
    bus_address = 16'h0003;
    guard = 0;
    while (cap_tx.size() < 3 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    chk("abort_reached", cap_tx.size() >= 3, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort_ce", spi_ce_n, 2'b11);
    chk("abort_start", spi_txn_start, 1'b0);
    chk("abort_wait", bus_wait, 1'b1);
    chk("abort_rx", bus_data_rx, 8'h00);
    bus_read = 1'b0;
    exp_rx   = 8'h00;
    in_hold  = 1'b0;
    cap_tx.delete();
    cap_ce.delete();
    gap_ce.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_access(1'b1, 1'b0, 16'h0002, 8'h00, 8'hC3, "rd_after_rst");

`ifdef SPI_MEM_SEQ_READ_EN
    do_access(1'b1, 1'b0, 16'h0100, 8'h00, 8'h5A, "seq_first");
    chk("seq_ce_between", spi_ce_n, 2'b10);
    do_access(1'b1, 1'b0, 16'h0101, 8'h00, 8'h6B, "seq_next");
    do_access(1'b1, 1'b0, 16'h0200, 8'h00, 8'h7C, "seq_break");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
